hazard_ctl: RTL

- Pipeline hazard scheduler for the rv32 five-stage core.
- Tracks destination registers of instructions in EX, MEM and WB with a small shadow pipeline.
- Compares them against the instruction in decode to generate stall, bubble, flush and operand-forwarding controls.
- Drives the stall/NOP inputs of the decode and execute control registers; serialises FENCE/SYSTEM instructions by draining the pipeline.

---
 rtl/hazard_ctl_if.sv | 31 +++
 rtl/hazard_ctl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl_if.sv
// Decode-side hazard bus: instruction/pipeline status in, stall/flush/forwarding controls and counters out.
interface hazard_ctl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_de;
  logic             valid_de;
  logic             br_taken;
  logic             mem_busy;
  logic             stall_fd;
  logic             stall_exe;
  logic             stall_mem;
  logic             bubble_exe;
  logic             flush_fd;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             drain_active;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_de, valid_de, br_taken, mem_busy,
    input  stall_fd, stall_exe, stall_mem, bubble_exe, flush_fd,
           fwd_a_sel, fwd_b_sel, drain_active, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_de, valid_de, br_taken, mem_busy,
    output stall_fd, stall_exe, stall_mem, bubble_exe, flush_fd,
           fwd_a_sel, fwd_b_sel, drain_active, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard scheduler for the rv32 five-stage core: shadow EX/MEM/WB destination tracking,
// load-use stalls, branch flushes, FENCE/SYSTEM draining and operand forwarding selects.
module hazard_ctl #(
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctl_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ex_stage_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
  } stage_t;

  typedef enum logic {RUN, DRAIN} state_t;

  ex_stage_t        ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  state_t           state_q;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       wr_c;
  logic       ld_c;
  logic       use1_c;
  logic       use2_c;
  logic       fs_c;
  logic       load_use_c;
  logic       drain_c;
  logic       flush_c;
  logic       bubble_c;
  logic       hazard_stall_c;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;
  logic       unused_bits;

  assign opcode = bus.instr_de[6:0];
  assign rd     = bus.instr_de[11:7];
  assign rs1    = bus.instr_de[19:15];
  assign rs2    = bus.instr_de[24:20];

  // Instruction class decode for the decode-stage instruction
  always_comb begin
    wr_c   = 1'b0;
    ld_c   = 1'b0;
    use1_c = 1'b0;
    use2_c = 1'b0;
    fs_c   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: wr_c = (rd != 5'd0);
      OP_JALR, OP_IMM: begin
        wr_c   = (rd != 5'd0);
        use1_c = 1'b1;
      end
      OP_LOAD: begin
        wr_c   = (rd != 5'd0);
        ld_c   = 1'b1;
        use1_c = 1'b1;
      end
      OP_REG: begin
        wr_c   = (rd != 5'd0);
        use1_c = 1'b1;
        use2_c = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use1_c = 1'b1;
        use2_c = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: fs_c = 1'b1;
      default: ;
    endcase
  end

  assign load_use_c = bus.valid_de & ex_q.v & ex_q.ld & ex_q.wr &
                      ((use1_c & (rs1 == ex_q.rd)) | (use2_c & (rs2 == ex_q.rd)));
  assign drain_c    = bus.valid_de & fs_c & (ex_q.v | mem_q.v | wb_q.v);

  // mem_busy freezes everything; a flush wins over a stall because the stalled instr is wrong-path
  assign flush_c        = bus.br_taken & ~bus.mem_busy;
  assign hazard_stall_c = ~flush_c & (load_use_c | drain_c);
  assign bubble_c       = ~bus.mem_busy & (flush_c | load_use_c | drain_c);

  // Forward selects for the instruction about to enter EX; current EX moves to MEM, MEM to WB
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (!bubble_c && use1_c) begin
      if ((rs1 != 5'd0) && ex_q.v && ex_q.wr && (ex_q.rd == rs1)) fwd_a_d = 2'd1;
      else if (mem_q.v && mem_q.wr && (mem_q.rd == rs1))          fwd_a_d = 2'd2;
    end
    if (!bubble_c && use2_c) begin
      if ((rs2 != 5'd0) && ex_q.v && ex_q.wr && (ex_q.rd == rs2)) fwd_b_d = 2'd1;
      else if (mem_q.v && mem_q.wr && (mem_q.rd == rs2))          fwd_b_d = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr};
      if (bubble_c) ex_q <= '0;
      else          ex_q <= '{v: bus.valid_de, rd: rd, wr: wr_c, ld: ld_c};
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      case (state_q)
        RUN:     if (drain_c && !flush_c) state_q <= DRAIN;
        DRAIN:   if (!drain_c || flush_c) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (hazard_stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_c && (flush_cnt_q != '1))        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.flush_fd     = flush_c;
  assign bus.bubble_exe   = bubble_c;
  assign bus.stall_fd     = bus.mem_busy | hazard_stall_c;
  assign bus.stall_exe    = bus.mem_busy;
  assign bus.stall_mem    = bus.mem_busy;
  assign bus.fwd_a_sel    = fwd_a_q;
  assign bus.fwd_b_sel    = fwd_b_q;
  assign bus.drain_active = (state_q == DRAIN);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

  // WB destination only matters for occupancy; the regfile is write-first
  assign unused_bits = ^{bus.instr_de[31:25], bus.instr_de[14:12], wb_q.rd, wb_q.wr};
endmodule
